// File: rtl/dmem_arb_pkg.sv
// Shared types and default geometry for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_ACK} arb_state_e;
  typedef enum logic {OWN_CORE, OWN_HOST} arb_owner_e;

  localparam int DMEM_DEPTH  = 8192;
  localparam int DMEM_ADDR_W = 13;
  localparam int DMEM_DATA_W = 32;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive cycles the host lost the port to the core.
module dmem_arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic a_rstn,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign at_limit = (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge a_rstn) begin
    if (!a_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the core LSU (combinational, priority)
// and a req/ack host port that is forced through after STARVE_LIMIT losses.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DMEM_ADDR_W,
  parameter int DATA_W       = DMEM_DATA_W,
  parameter int DEPTH        = DMEM_DEPTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                a_rstn,
  input  logic                core_mem_en,
  input  logic                core_we,
  input  logic [ADDR_W-1:0]   core_addr,
  input  logic [DATA_W-1:0]   core_wdata,
  input  logic [DATA_W/8-1:0] core_be,
  output logic [DATA_W-1:0]   core_rdata,
  output logic                core_stall,
  input  logic                host_req,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  input  logic [DATA_W/8-1:0] host_be,
  output logic                host_ack,
  output logic [DATA_W-1:0]   host_rdata,
  output logic                host_err,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner;
  logic              host_ack_q, host_ack_d;
  logic              host_err_q, host_err_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_oor;
  logic              host_take;
  logic              starve_inc;
  logic              at_limit;

  assign host_oor = ({1'b0, host_addr} >= (ADDR_W + 1)'(DEPTH));

  // An out-of-range host request needs no port, so it is accepted at once
  // without displacing the core.
  always_comb begin
    host_take  = 1'b0;
    starve_inc = 1'b0;
    if (state_q == ARB_IDLE && host_req) begin
      if (host_oor || !core_mem_en || at_limit) begin
        host_take = 1'b1;
      end else begin
        starve_inc = 1'b1;
      end
    end
    owner = (host_take && !host_oor) ? OWN_HOST : OWN_CORE;
  end

  dmem_arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .a_rstn  (a_rstn),
    .inc     (starve_inc),
    .clr     (host_take),
    .at_limit(at_limit)
  );

  always_comb begin
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    mem_be     = core_be;
    mem_we     = core_mem_en & core_we;
    core_stall = 1'b0;
    if (owner == OWN_HOST) begin
      mem_addr   = host_addr;
      mem_wdata  = host_wdata;
      mem_be     = host_be;
      mem_we     = host_we;
      core_stall = core_mem_en;
    end
    if (!a_rstn) begin
      mem_we     = 1'b0;
      core_stall = 1'b0;
    end
  end

  assign core_rdata = mem_rdata;

  always_comb begin
    state_d      = ARB_IDLE;
    host_ack_d   = 1'b0;
    host_err_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    if (host_take) begin
      state_d      = ARB_ACK;
      host_ack_d   = 1'b1;
      host_err_d   = host_oor;
      host_rdata_d = host_oor ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge a_rstn) begin
    if (!a_rstn) begin
      state_q      <= ARB_IDLE;
      host_ack_q   <= 1'b0;
      host_err_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      host_ack_q   <= host_ack_d;
      host_err_q   <= host_err_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign host_ack   = host_ack_q;
  assign host_err   = host_err_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed scoreboard bench for dmem_port_arbiter, built with ADDR_W=14 so
// that out-of-range host addresses can be exercised.
module tb_dmem_port_arbiter;

   localparam int ADDR_W       = 14;
   localparam int DATA_W       = 32;
   localparam int BE_W         = 4;
   localparam int DEPTH        = 8192;
   localparam int STARVE_LIMIT = 4;

   logic              clk = 1'b0;
   logic              a_rstn;
   logic              core_mem_en;
   logic              core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [BE_W-1:0]   core_be;
   logic [DATA_W-1:0] core_rdata;
   logic              core_stall;
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic [BE_W-1:0]   host_be;
   logic              host_ack;
   logic [DATA_W-1:0] host_rdata;
   logic              host_err;
   logic              mem_we;
   logic [BE_W-1:0]   mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   typedef struct packed {
      logic              checkData;
      logic [DATA_W-1:0] rdata;
      logic              err;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   logic [DATA_W-1:0] tbMem [0:DEPTH-1];

   // Free-running 100 MHz clock; inputs change on the falling edge.
   always #5 clk = ~clk;

   dmem_port_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk        (clk),
      .a_rstn     (a_rstn),
      .core_mem_en(core_mem_en),
      .core_we    (core_we),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_be    (core_be),
      .core_rdata (core_rdata),
      .core_stall (core_stall),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_be    (host_be),
      .host_ack   (host_ack),
      .host_rdata (host_rdata),
      .host_err   (host_err),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Behavioural data memory: combinational read, byte-enabled synchronous write.
   assign mem_rdata = (mem_addr < ADDR_W'(DEPTH)) ? tbMem[mem_addr[12:0]] : '0;

   always @(posedge clk) begin
      if (mem_we && mem_addr < ADDR_W'(DEPTH)) begin
         for (int b = 0; b < BE_W; b++) begin
            if (mem_be[b]) tbMem[mem_addr[12:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Monitor: every host_ack pops the oldest expected response.
   always @(negedge clk) begin
      if (a_rstn === 1'b1 && host_ack === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack: got host_ack=1, expected no pending transaction");
         end else begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("ack_err", {31'b0, host_err}, {31'b0, e.err});
            if (e.checkData) checkOutput("ack_rdata", host_rdata, e.rdata);
         end
      end
   end

   task automatic applyStimulus(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be);
      host_req   = req;
      host_we    = we;
      host_addr  = addr;
      host_wdata = wdata;
      host_be    = be;
   endtask

   task automatic driveCore(input logic en, input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [BE_W-1:0] be);
      core_mem_en = en;
      core_we     = we;
      core_addr   = addr;
      core_wdata  = wdata;
      core_be     = be;
   endtask

   task automatic driveIdle();
      driveCore(1'b0, 1'b0, '0, '0, '0);
      applyStimulus(1'b0, 1'b0, '0, '0, '0);
   endtask

   // Bounded wait for host_ack; drops host_req in the ack cycle.
   task automatic waitAck(input string name, input int expCycles, input int maxCycles);
      int n = 0;
      bit seen = 1'b0;
      while (n < maxCycles && !seen) begin
         @(negedge clk);
         n++;
         if (host_ack === 1'b1) seen = 1'b1;
      end
      host_req = 1'b0;
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_ack_timeout: got no host_ack, expected one within %0d cycles", name, maxCycles);
      end else begin
         checkOutput({name, "_latency"}, n, expCycles);
      end
   endtask

   // Core loads 0x010 every cycle while a host read waits; host must win the last tie.
   task automatic starveRun(input string name, input logic [ADDR_W-1:0] hAddr, input logic [DATA_W-1:0] expData);
      driveCore(1'b1, 1'b0, 14'h010, '0, '0);
      applyStimulus(1'b1, 1'b0, hAddr, '0, '0);
      expQ.push_back('{checkData: 1'b1, rdata: expData, err: 1'b0});
      for (int i = 1; i <= STARVE_LIMIT; i++) begin
         #1;
         checkOutput($sformatf("%s_stall_c%0d", name, i), {31'b0, core_stall}, (i == STARVE_LIMIT) ? 32'd1 : 32'd0);
         checkOutput($sformatf("%s_addr_c%0d", name, i), {18'b0, mem_addr}, (i == STARVE_LIMIT) ? {18'b0, hAddr} : 32'h010);
         @(negedge clk);
      end
      checkOutput({name, "_ack"}, {31'b0, host_ack}, 32'd1);
      host_req = 1'b0;
      #1;
      checkOutput({name, "_ack_cycle_stall"}, {31'b0, core_stall}, 32'd0);
      checkOutput({name, "_core_rdata"}, core_rdata, 32'hDEADBEEF);
      @(negedge clk);
      driveIdle();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence.
   initial begin
      for (int i = 0; i < DEPTH; i++) tbMem[i] <= '0;
      tbMem[14'h020] <= 32'h12345678;
      tbMem[14'h040] <= 32'h11223344;

      // Reset: outputs quiet even with both requesters active.
      a_rstn = 1'b0;
      driveCore(1'b1, 1'b1, 14'h001, 32'hFFFFFFFF, 4'hF);
      applyStimulus(1'b1, 1'b1, 14'h002, 32'hFFFFFFFF, 4'hF);
      #3;
      checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
      checkOutput("rst_core_stall", {31'b0, core_stall}, 32'd0);
      checkOutput("rst_host_ack", {31'b0, host_ack}, 32'd0);
      checkOutput("rst_host_err", {31'b0, host_err}, 32'd0);
      checkOutput("rst_host_rdata", host_rdata, 32'd0);
      @(negedge clk);
      driveIdle();
      #2 a_rstn = 1'b1;
      @(negedge clk);

      // Host write with the core idle.
      applyStimulus(1'b1, 1'b1, 14'h010, 32'hDEADBEEF, 4'hF);
      expQ.push_back('{checkData: 1'b0, rdata: '0, err: 1'b0});
      #1;
      checkOutput("t1_mem_we", {31'b0, mem_we}, 32'd1);
      checkOutput("t1_stall", {31'b0, core_stall}, 32'd0);
      checkOutput("t1_mem_addr", {18'b0, mem_addr}, 32'h010);
      checkOutput("t1_mem_wdata", mem_wdata, 32'hDEADBEEF);
      waitAck("t1", 1, 8);
      checkOutput("t1_mem_content", tbMem[14'h010], 32'hDEADBEEF);
      @(negedge clk);

      // Host read back.
      applyStimulus(1'b1, 1'b0, 14'h010, '0, '0);
      expQ.push_back('{checkData: 1'b1, rdata: 32'hDEADBEEF, err: 1'b0});
      #1;
      checkOutput("t2_mem_we", {31'b0, mem_we}, 32'd0);
      waitAck("t2", 1, 8);
      @(negedge clk);

      // Starvation bound.
      starveRun("t3", 14'h020, 32'h12345678);

      // Out-of-range host write alongside a core load.
      driveCore(1'b1, 1'b0, 14'h010, '0, '0);
      applyStimulus(1'b1, 1'b1, 14'h2000, 32'hFFFFFFFF, 4'hF);
      expQ.push_back('{checkData: 1'b1, rdata: '0, err: 1'b1});
      #1;
      checkOutput("t4_mem_we", {31'b0, mem_we}, 32'd0);
      checkOutput("t4_stall", {31'b0, core_stall}, 32'd0);
      checkOutput("t4_mem_addr", {18'b0, mem_addr}, 32'h010);
      waitAck("t4", 1, 8);
      @(negedge clk);
      driveIdle();
      @(negedge clk);

      // Core partial store during the host ACK cycle.
      applyStimulus(1'b1, 1'b1, 14'h030, 32'hCAFEF00D, 4'hF);
      expQ.push_back('{checkData: 1'b0, rdata: '0, err: 1'b0});
      @(negedge clk);
      checkOutput("t5_ack", {31'b0, host_ack}, 32'd1);
      host_req = 1'b0;
      driveCore(1'b1, 1'b1, 14'h040, 32'hAABBCCDD, 4'h3);
      #1;
      checkOutput("t5_stall", {31'b0, core_stall}, 32'd0);
      checkOutput("t5_mem_we", {31'b0, mem_we}, 32'd1);
      checkOutput("t5_mem_addr", {18'b0, mem_addr}, 32'h040);
      checkOutput("t5_mem_be", {28'b0, mem_be}, 32'h3);
      @(negedge clk);
      driveIdle();
      checkOutput("t5_partial_store", tbMem[14'h040], 32'h1122CCDD);
      checkOutput("t5_host_store", tbMem[14'h030], 32'hCAFEF00D);
      @(negedge clk);

      // Reset lands in the host grant cycle after the counter reached its limit.
      driveCore(1'b1, 1'b0, 14'h010, '0, '0);
      applyStimulus(1'b1, 1'b1, 14'h050, 32'h55555555, 4'hF);
      for (int i = 1; i < STARVE_LIMIT; i++) begin
         #1;
         checkOutput($sformatf("t6_lose_stall_c%0d", i), {31'b0, core_stall}, 32'd0);
         @(negedge clk);
      end
      #1;
      checkOutput("t6_grant_stall", {31'b0, core_stall}, 32'd1);
      #1 a_rstn = 1'b0;
      #1;
      checkOutput("t6_rst_mem_we", {31'b0, mem_we}, 32'd0);
      checkOutput("t6_rst_stall", {31'b0, core_stall}, 32'd0);
      @(negedge clk);
      driveIdle();
      checkOutput("t6_rst_ack", {31'b0, host_ack}, 32'd0);
      checkOutput("t6_rst_rdata", host_rdata, 32'd0);
      #2 a_rstn = 1'b1;
      @(negedge clk);
      checkOutput("t6_post_ack", {31'b0, host_ack}, 32'd0);
      checkOutput("t6_no_write", tbMem[14'h050], 32'd0);
      starveRun("t6_post", 14'h020, 32'h12345678);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", expQ.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
